// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU function codes, datapath width and multiply-sequencer states
package alu_pkg;
  localparam int XLEN = 32;
  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_OR  = 4'b0001;
  localparam logic [3:0] FN_ADD = 4'b0010;
  localparam logic [3:0] FN_SUB = 4'b0110;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} mul_state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add RV32 MUL on the shared ALU; MUL_EARLY_EXIT_EN stops once the remaining multiplier is zero
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int XLEN_P = alu_pkg::XLEN,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [XLEN_P-1:0] op_a,
  input  logic [XLEN_P-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [XLEN_P-1:0] result,
  output logic              alu_own,
  output logic [XLEN_P-1:0] alu_in1,
  output logic [XLEN_P-1:0] alu_in2,
  output logic [3:0]        alu_ctrl,
  input  logic [XLEN_P-1:0] alu_out
);
  mul_state_t state, state_nx;
  logic [XLEN_P-1:0] acc, a_reg, b_reg;
  logic [CNT_W-1:0] cnt;
  logic run, last;
  assign run = state == RUN;
`ifdef MUL_EARLY_EXIT_EN
  assign last = cnt == CNT_W'(XLEN_P - 1) || b_reg[XLEN_P-1:1] == '0;
`else
  assign last = cnt == CNT_W'(XLEN_P - 1);
`endif
  // ALU drive is decoded from state only, so an async reset frees the mux immediately
  assign busy     = run;
  assign alu_own  = run;
  assign done     = state == DONE;
  assign alu_in1  = run && b_reg[0] ? a_reg : '0;
  assign alu_in2  = run ? acc : '0;
  assign alu_ctrl = run ? FN_ADD : FN_AND;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start && !kill ? RUN : IDLE;
      RUN:     state_nx = kill ? IDLE : last ? DONE : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      acc    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (kill) begin
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      cnt   <= '0;
    end else if (state == IDLE && start) begin
      acc   <= '0;
      a_reg <= op_a;
      b_reg <= op_b;
      cnt   <= '0;
    end else if (run) begin
      acc   <= alu_out;
      a_reg <= a_reg << 1;
      b_reg <= b_reg >> 1;
      cnt   <= cnt + CNT_W'(1);
      if (last) result <= alu_out;
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed checks of alu_mul_seq with a behavioural ALU closing the alu_out loop
module tb_alu_mul_seq;
  import alu_pkg::*;
  logic clk = 0, reset = 0, start = 0, kill = 0;
  logic [31:0] op_a = 0, op_b = 0, result, alu_in1, alu_in2, alu_out;
  logic busy, done, alu_own;
  logic [3:0] alu_ctrl;
  int checks = 0, errors = 0;

  alu_mul_seq dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .alu_own(alu_own), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  always_comb
    alu_out = alu_ctrl == FN_ADD ? alu_in2 + alu_in1 :
              alu_ctrl == FN_SUB ? alu_in2 - alu_in1 :
              alu_ctrl == FN_OR  ? alu_in2 | alu_in1 : alu_in2 & alu_in1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int run_len(input logic [31:0] b);
    int r = 32;
`ifdef MUL_EARLY_EXIT_EN
    r = 1;
    for (int i = 0; i < 32; i++) if (b[i]) r = i + 1;
`endif
    return r;
  endfunction

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit poke);
    int n = 0;
    op_a = a;
    op_b = b;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    if (poke) begin
      op_a = 32'd5;
      op_b = 32'd5;
    end
    while (busy && n < 40) begin
      n++;
      if (n == 1) begin
        chk({tag, "_own"}, 32'(alu_own), 32'd1);
        chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(FN_ADD));
      end
      start = poke && n == 4;
      @(posedge clk); #1;
    end
    start = 0;
    chk({tag, "_runlen"}, n, run_len(b));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_free_own"}, 32'(alu_own), 32'd0);
    chk({tag, "_free_ctrl"}, 32'(alu_ctrl), 32'(FN_AND));
    start = poke;
    @(posedge clk); #1;
    start = 0;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ctrl", 32'(alu_ctrl), 32'(FN_AND));
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    run_mul("basic", 32'd7, 32'd6, 32'd42, 0);
    run_mul("neg1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 0);
    run_mul("wrap", 32'h8000_0000, 32'd2, 32'd0, 0);
    run_mul("ign_start", 32'h11, 32'd3, 32'h33, 1);
    op_a = 32'd3;
    op_b = 32'd5;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1 kill = 1;
    @(posedge clk); #1;
    kill = 0;
    chk("kill_busy", 32'(busy), 32'd0);
    chk("kill_done", 32'(done), 32'd0);
    chk("kill_result", result, 32'h33);
    @(posedge clk); #1;
    chk("kill_nodone", 32'(done), 32'd0);
    run_mul("after_kill", 32'd3, 32'd5, 32'd15, 0);
    op_a = 32'd9;
    start = 1;
    kill = 1;
    @(posedge clk); #1;
    start = 0;
    kill = 0;
    chk("startkill_busy", 32'(busy), 32'd0);
    chk("startkill_own", 32'(alu_own), 32'd0);
    run_mul("b_zero", 32'h1234, 32'd0, 32'd0, 0);
    run_mul("b_three", 32'd9, 32'd3, 32'd27, 0);
    op_a = 32'h1234;
    op_b = 32'd7;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #1 reset = 0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_own", 32'(alu_own), 32'd0);
    chk("mrst_in1", alu_in1, 32'd0);
    chk("mrst_in2", alu_in2, 32'd0);
    chk("mrst_ctrl", 32'(alu_ctrl), 32'(FN_AND));
    chk("mrst_result", result, 32'd0);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    run_mul("post_rst", 32'h1234, 32'h10, 32'h0001_2340, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
